wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback (the result-mux output) and late load returns from the data cache after a miss.
- Late returns are held in a small FIFO and drained into free writeback slots.
- Raises a pipeline stall when the FIFO is full.
- Publishes a pending-destination mask to the hazard unit.
- Sits between the writeback stage / cache refill path and the register file.

Parameters:
- WIDTH, 32, data width of the register-file write data.
- DEPTH, 4, late-return FIFO entries (power of two, >=2).
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_rd  in  ADDR_W  pipeline destination register.
- wb_result  in  WIDTH  selected writeback value (result-mux output).
- ld_valid  in  1  late load return from the cache.
- ld_rd  in  ADDR_W  destination of the late load.
- ld_data  in  WIDTH  late load data.
- ld_ready  out  1  FIFO can accept a late return this cycle.
- pipe_stall  out  1  writeback stage must hold its request.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_W  register-file write address (registered).
- rf_wdata  out  WIDTH  register-file write data (registered).
- rd_pending  out  32  one-hot OR of the rd of every valid FIFO entry (combinational from state).

Behaviour:
- Reset (rst_n=0 at edge):
  - FIFO cleared: count=0, pointers=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - rd_pending=0.
  - Reset mid-operation discards all buffered returns with no write.
- Combinational outputs:
  - ld_ready = (count < DEPTH).
  - pipe_stall = wb_valid && (count == DEPTH).
- x0 handling: any request with rd==0 is a no-op.
  - It never occupies the port and is never enqueued.
  - A late load to x0 is accepted (when ld_ready) and dropped.
- Port grant each cycle, first match wins:
  1. FULL: count==DEPTH -> FIFO head wins; pipeline stalled.
  2. PIPE: wb_valid && wb_rd!=0 -> pipeline wins.
  3. DRAIN: count>0 -> FIFO head wins.
  4. BYPASS: ld_valid && ld_rd!=0 && count==0 -> late return written directly, not enqueued.
  5. Otherwise idle.
- Latency: the granted request appears on rf_we/rf_waddr/rf_wdata at the next rising edge, held one cycle. rf_we=0 on idle cycles.
- Enqueue: ld_valid && ld_ready && ld_rd!=0 && not BYPASS -> push at tail.
- Simultaneous events:
  - Push and pop in the same cycle is legal when count<DEPTH; count is unchanged.
  - When full, ld_ready=0 even during a pop, so there is no pass-through.
- Count stays within 0..DEPTH. Pointers wrap modulo DEPTH.
- rd_pending updates one cycle after enqueue/dequeue, from registered state.
- Ordering / hazards:
  - The FIFO drains strictly in arrival order.
  - The hazard unit must not issue a pipeline write to an rd set in rd_pending.
  - Bench assertion: wb_valid && wb_rd!=0 && rd_pending[wb_rd] never true.
  - Two FIFO entries with the same rd are legal; the later one lands last.
- FSM: the arbitration mode is derived per cycle from count and requests, and needs no extra state register.
  - Encode it as an enum for waveform visibility: IDLE, PIPE, DRAIN, BYPASS, FULL.

Decomposition:
- Shared package wb_pkg holds:
  - typedef wb_req_t {logic [ADDR_W-1:0] rd; logic [WIDTH-1:0] data;}
  - grant enum wb_grant_e {GNT_IDLE, GNT_PIPE, GNT_DRAIN, GNT_BYPASS, GNT_FULL}
  - constant REG_ZERO=5'd0.
- One sub-module, wb_fifo: parameterised DEPTH sync FIFO with push/pop/count, head output and a per-entry valid+rd vector used for rd_pending.
- Arbitration and output registers stay in wb_port_arbiter.

Test Plan:
- Reset: drive rst_n=0 with count=3 and ld_valid=1 -> after one edge, rf_we=0, rd_pending=0, ld_ready=1, no write of the buffered data ever appears.
- Pipe priority, x0 drop:
  - wb_valid=1, wb_rd=5, wb_result=0x1234, and the same cycle ld_valid=1, ld_rd=7, ld_data=0xAAAA with FIFO empty -> next edge rf_we=1, rf_waddr=5, rf_wdata=0x1234; rd_pending[7]=1.
  - Following idle cycle -> rf_waddr=7, rf_wdata=0xAAAA, rd_pending=0.
  - ld_rd=0, ld_data=0xFFFF with ld_valid=1 and ld_ready=1 -> accepted and dropped: no enqueue, rf_we stays 0, rd_pending unchanged.
- Bypass: FIFO empty, wb_valid=0, ld_valid=1, ld_rd=3, ld_data=0xBEEF -> next edge rf_we=1, rf_waddr=3, rf_wdata=0xBEEF; count stays 0.
- Full/stall: fill 4 returns (rd 8..11) while wb_valid=1 every cycle with wb_rd=1 -> ld_ready=0 once count=4 and pipe_stall=1; the FIFO then writes rd 8 first; pipe_stall drops once count=3.
- Wrap-around: push and pop continuously for 10 cycles with distinct rd 12..21 -> writes appear in exact order, count never exceeds 4, no data loss across pointer wrap.
- x0 pipeline: wb_valid=1, wb_rd=0 with count=2 -> the FIFO head drains that cycle and rf_we never carries rf_waddr=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: request record,
// grant modes and the hard-wired zero register index.
package wb_pkg;

   localparam int WB_WIDTH  = 32;
   localparam int WB_ADDR_W = 5;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_WIDTH-1:0]  data;
   } wb_req_t;

   typedef enum logic [2:0] {
      GNT_IDLE,
      GNT_PIPE,
      GNT_DRAIN,
      GNT_BYPASS,
      GNT_FULL
   } wb_grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for late load returns; exposes per-entry valid and
// destination so the owner can build a pending-register mask.
module wb_fifo #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [ADDR_W-1:0]           push_rd,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   output logic [ADDR_W-1:0]           head_rd,
   output logic [WIDTH-1:0]            head_data,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic [DEPTH-1:0]            entry_valid,
   output logic [DEPTH*ADDR_W-1:0]     entry_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [ADDR_W-1:0] rd_mem   [DEPTH];
   logic [WIDTH-1:0]  data_mem [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && (count_q < CNT_W'(DEPTH));
   assign do_pop  = pop && (count_q != '0);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr          <= wr_ptr + PTR_W'(1);
            valid_q[wr_ptr] <= 1'b1;
         end
         if (do_pop) begin
            rd_ptr          <= rd_ptr + PTR_W'(1);
            valid_q[rd_ptr] <= 1'b0;
         end
         count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end

   always_comb begin
      entry_rd = '0;
      for (int i = 0; i < DEPTH; i++) begin
         entry_rd[i*ADDR_W +: ADDR_W] = rd_mem[i];
      end
   end

   assign head_rd     = rd_mem[rd_ptr];
   assign head_data   = data_mem[rd_ptr];
   assign count       = count_q;
   assign entry_valid = valid_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and late
// load returns; late returns queue in wb_fifo and drain into free slots.
module wb_port_arbiter
   import wb_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [WIDTH-1:0]  wb_result,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_rd,
   input  logic [WIDTH-1:0]  ld_data,
   output logic              ld_ready,
   output logic              pipe_stall,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [WIDTH-1:0]  rf_wdata,
   output logic [31:0]       rd_pending
);

   localparam int CNT_W = $clog2(DEPTH+1);

   wb_grant_e             grant;
   logic [CNT_W-1:0]      count;
   logic [ADDR_W-1:0]     head_rd;
   logic [WIDTH-1:0]      head_data;
   logic [DEPTH-1:0]      entry_valid;
   logic [DEPTH*ADDR_W-1:0] entry_rd;
   logic                  full;
   logic                  empty;
   logic                  wb_live;
   logic                  ld_live;
   logic                  fifo_push;
   logic                  fifo_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign wb_live = wb_valid && (wb_rd != ADDR_W'(REG_ZERO));
   assign ld_live = ld_valid && (ld_rd != ADDR_W'(REG_ZERO));

   assign ld_ready   = !full;
   assign pipe_stall = wb_valid && full;

   // Priority order: a full queue must drain before anything else, otherwise
   // the in-order pipeline wins and queued returns fill idle slots.
   always_comb begin
      grant = GNT_IDLE;
      if (full) begin
         grant = GNT_FULL;
      end else if (wb_live) begin
         grant = GNT_PIPE;
      end else if (!empty) begin
         grant = GNT_DRAIN;
      end else if (ld_live) begin
         grant = GNT_BYPASS;
      end
   end

   assign fifo_pop  = (grant == GNT_FULL) || (grant == GNT_DRAIN);
   assign fifo_push = ld_live && ld_ready && (grant != GNT_BYPASS);

   wb_fifo #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (fifo_push),
      .push_rd     (ld_rd),
      .push_data   (ld_data),
      .pop         (fifo_pop),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .count       (count),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // Address and data hold their last value on idle cycles; only rf_we drops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= 1'b0;
         case (grant)
            GNT_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= wb_rd;
               rf_wdata <= wb_result;
            end
            GNT_FULL, GNT_DRAIN: begin
               rf_we    <= 1'b1;
               rf_waddr <= head_rd;
               rf_wdata <= head_data;
            end
            GNT_BYPASS: begin
               rf_we    <= 1'b1;
               rf_waddr <= ld_rd;
               rf_wdata <= ld_data;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      rd_pending = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) begin
            rd_pending = rd_pending | (32'(1) << entry_rd[i*ADDR_W +: ADDR_W]);
         end
      end
   end

endmodule
